mul_pipe: RTL and testbench



---
 rtl/mul_pkg.sv | 42 ++++
 rtl/mul_pipe_if.sv | 34 +++
 rtl/mul_pipe_stage.sv | 33 +++
 rtl/mul_pipe.sv | 129 ++++++++++++
 tb/tb_mul_pipe.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the pipelined signed multiply/MAC unit.
//   mul_op_t   : operating mode carried alongside each beat
//   smax/smin  : signed range limits of a given width, in a wide container
//   sat_trunc  : range check plus optional clip, returns {ovf, value}
package mul_pkg;

  typedef enum logic [1:0] {
    MUL  = 2'b00,
    MULH = 2'b01,
    MAC  = 2'b10,
    MACL = 2'b11
  } mul_op_t;

  // Largest supported operand width; VAL_W holds any product or accumulator.
  localparam int unsigned MAX_W = 64;
  localparam int unsigned VAL_W = 2 * MAX_W + 32;

  function automatic logic signed [VAL_W-1:0] smax(input int unsigned width);
    return signed'((VAL_W'(1) << (width - 1)) - VAL_W'(1));
  endfunction

  function automatic logic signed [VAL_W-1:0] smin(input int unsigned width);
    return ~smax(width);
  endfunction

  // Bit VAL_W flags a value outside the signed width range; the low bits
  // carry the clipped value when sat is set, otherwise the value unchanged.
  function automatic logic [VAL_W:0] sat_trunc(input logic signed [VAL_W-1:0] value,
                                               input int unsigned width,
                                               input logic sat);
    logic signed [VAL_W-1:0] hi;
    logic signed [VAL_W-1:0] lo;
    logic over;
    logic under;
    hi    = smax(width);
    lo    = smin(width);
    over  = value > hi;
    under = value < lo;
    return {over | under, (sat && over) ? hi : (sat && under) ? lo : value};
  endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Operand/result handshake bundle for mul_pipe.
//   in_valid/in_ready/a/b/op      : operand beat (master drives)
//   out_valid/out_ready/result/ovf : result beat (slave drives, master accepts)
//   acc                            : accumulator readback
interface mul_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GUARD = 4
);
  import mul_pkg::*;

  localparam int unsigned ACC_W = 2 * WIDTH + GUARD;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  mul_op_t                 op;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] result;
  logic                    ovf;
  logic signed [ACC_W-1:0] acc;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, ovf, acc
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, ovf, acc
  );

endinterface

// File: rtl/mul_pipe_stage.sv
// One enable-gated pipeline slice carrying product, op and valid.
//   clk, reset : clock, async active-high reset
//   en         : advance (low while the output is stalled)
//   d_* / q_*  : incoming / registered beat
module mul_pipe_stage
  import mul_pkg::*;
#(
  parameter int unsigned P_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic signed [P_W-1:0] d_p,
  input  mul_op_t               d_op,
  input  logic                  d_v,
  output logic signed [P_W-1:0] q_p,
  output mul_op_t               q_op,
  output logic                  q_v
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_v  <= 1'b0;
      q_p  <= '0;
      q_op <= MUL;
    end else if (en) begin
      q_v  <= d_v;
      q_p  <= d_p;
      q_op <= d_op;
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Pipelined signed multiply / multiply-accumulate with valid/ready flow control.
//   clk, reset : clock, async active-high reset
//   bus        : mul_pipe_if slave (operands in; result, ovf, acc out)
// The product is formed on the incoming operands, carried through LATENCY-1
// slices, and resolved (MUL/MULH/MAC/MACL, saturation) into the output register.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned GUARD   = 4,
  parameter int unsigned SAT     = 1
) (
  input logic       clk,
  input logic       reset,
  mul_pipe_if.slave bus
);

  localparam int unsigned P_W   = 2 * WIDTH;
  localparam int unsigned ACC_W = 2 * WIDTH + GUARD;

  logic                    stall;
  logic                    out_valid_q;
  logic signed [WIDTH-1:0] result_q;
  logic                    ovf_q;
  logic signed [ACC_W-1:0] acc_q;

  // Whole pipeline freezes while a result waits for its consumer.
  assign stall = out_valid_q && !bus.out_ready;

  // Full-width signed product; synthesis maps this onto a dedicated multiplier.
  logic signed [P_W-1:0] prod_c;
  assign prod_c = P_W'(bus.a) * P_W'(bus.b);

  // Element 0 is the incoming beat; element k is the output of slice k.
  logic signed [P_W-1:0] pipe_p  [LATENCY];
  mul_op_t               pipe_op [LATENCY];
  logic                  pipe_v  [LATENCY];

  assign pipe_p[0]  = prod_c;
  assign pipe_op[0] = bus.op;
  assign pipe_v[0]  = bus.in_valid;

  for (genvar g = 1; g < LATENCY; g++) begin : g_stage
    mul_pipe_stage #(.P_W(P_W)) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (!stall),
      .d_p   (pipe_p[g-1]),
      .d_op  (pipe_op[g-1]),
      .d_v   (pipe_v[g-1]),
      .q_p   (pipe_p[g]),
      .q_op  (pipe_op[g]),
      .q_v   (pipe_v[g])
    );
  end

  logic signed [P_W-1:0]   fin_p;
  mul_op_t                 fin_op;
  logic                    fin_v;
  assign fin_p  = pipe_p[LATENCY-1];
  assign fin_op = pipe_op[LATENCY-1];
  assign fin_v  = pipe_v[LATENCY-1];

  logic signed [ACC_W-1:0] p_ext_c;
  logic signed [ACC_W-1:0] mac_sum_c;
  logic signed [ACC_W-1:0] acc_nxt_c;
  logic                    acc_we_c;
  logic signed [VAL_W-1:0] sel_c;
  logic [VAL_W:0]          st_c;
  logic [WIDTH-1:0]        res_c;
  logic                    ovf_c;

  // Final-stage resolution: pick the value to range-check and the acc update.
  always_comb begin
    p_ext_c   = ACC_W'(fin_p);
    mac_sum_c = acc_q + p_ext_c;
    acc_we_c  = 1'b0;
    acc_nxt_c = acc_q;
    sel_c     = VAL_W'(fin_p);
    case (fin_op)
      MAC: begin
        sel_c     = VAL_W'(mac_sum_c);
        acc_we_c  = 1'b1;
        acc_nxt_c = mac_sum_c;
      end
      MACL: begin
        acc_we_c  = 1'b1;
        acc_nxt_c = p_ext_c;
      end
      default: ;
    endcase
    st_c  = sat_trunc(sel_c, WIDTH, SAT != 0);
    ovf_c = st_c[VAL_W];
    res_c = st_c[WIDTH-1:0];
    if (fin_op == MULH) begin
      res_c = fin_p[P_W-1:WIDTH];
      ovf_c = 1'b0;
    end
  end

  // Only the low WIDTH bits and the flag of the range check are consumed.
  logic unused_st;
  assign unused_st = ^st_c;

  // Output register; acc moves only when a MAC/MACL beat lands here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else if (!stall) begin
      out_valid_q <= fin_v;
      if (fin_v) begin
        result_q <= res_c;
        ovf_q    <= ovf_c;
        if (acc_we_c) acc_q <= acc_nxt_c;
      end
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe at WIDTH=8, LATENCY=2: a saturating instance
// and a wrapping instance fed the same operand stream.
module tb_mul_pipe;
  import mul_pkg::*;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  mul_pipe_if #(.WIDTH(8), .GUARD(4)) bus ();
  mul_pipe_if #(.WIDTH(8), .GUARD(4)) bus0 ();

  mul_pipe #(.WIDTH(8), .LATENCY(2), .GUARD(4), .SAT(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mul_pipe #(.WIDTH(8), .LATENCY(2), .GUARD(4), .SAT(0)) u_dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  assign bus0.in_valid  = bus.in_valid;
  assign bus0.a         = bus.a;
  assign bus0.b         = bus.b;
  assign bus0.op        = bus.op;
  assign bus0.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for a cycle, then idle until it reaches the output.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input mul_op_t iop);
    bus.in_valid = 1'b1;
    bus.a        = ia;
    bus.b        = ib;
    bus.op       = iop;
    step();
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = MUL;
    bus.out_ready = 1'b1;
    #12;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    vectors++; if (bus.result !== 8'h00) begin miscompares++; $display("FAIL reset_result got %h want 00", bus.result); end
    vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    vectors++; if (bus.acc !== 20'h0) begin miscompares++; $display("FAIL reset_acc got %h want 0", bus.acc); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    vectors++; if (bus0.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wrap_out_valid got %b want 0", bus0.out_valid); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [7:0] va [3];
    logic [7:0] vb [3];
    logic [7:0] ve [3];
    va = '{8'(3), 8'(-5), 8'(0)};
    vb = '{8'(4), 8'(6), 8'(-128)};
    ve = '{8'(12), 8'(-30), 8'(0)};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        bus.in_valid = 1'b1;
        bus.op       = MUL;
        bus.a        = va[i];
        bus.b        = vb[i];
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, bus.in_ready); end
      if (i >= 1) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.result !== ve[i-1] || bus.ovf !== 1'b0) begin
          miscompares++;
          $display("FAIL stream_out[%0d] got v=%b r=%h o=%b want v=1 r=%h o=0", i-1, bus.out_valid, bus.result, bus.ovf, ve[i-1]);
        end
      end
    end
    step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_saturation();
    mul_op_t    ops [6];
    logic [7:0] va  [6];
    logic [7:0] vb  [6];
    logic [7:0] r1  [6];
    logic       o1  [6];
    logic [7:0] r0  [6];
    logic       o0  [6];
    ops = '{MUL, MUL, MUL, MULH, MUL, MULH};
    va  = '{8'(100), 8'(-128), 8'(-128), 8'(-128), 8'(0), 8'(100)};
    vb  = '{8'(100), 8'(127), 8'(-128), 8'(-128), 8'(-128), 8'(100)};
    r1  = '{8'h7f, 8'h80, 8'h7f, 8'h40, 8'h00, 8'h27};
    o1  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    r0  = '{8'h10, 8'h80, 8'h00, 8'h40, 8'h00, 8'h27};
    o0  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], ops[i]);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.result !== r1[i] || bus.ovf !== o1[i]) begin
        miscompares++;
        $display("FAIL sat[%0d] got v=%b r=%h o=%b want v=1 r=%h o=%b", i, bus.out_valid, bus.result, bus.ovf, r1[i], o1[i]);
      end
      vectors++;
      if (bus0.out_valid !== 1'b1 || bus0.result !== r0[i] || bus0.ovf !== o0[i]) begin
        miscompares++;
        $display("FAIL wrap[%0d] got v=%b r=%h o=%b want v=1 r=%h o=%b", i, bus0.out_valid, bus0.result, bus0.ovf, r0[i], o0[i]);
      end
    end
  endtask

  task automatic test_accumulate();
    mul_op_t     ops [4];
    logic [7:0]  va  [4];
    logic [7:0]  vb  [4];
    logic [7:0]  er  [4];
    logic        eo  [4];
    logic [19:0] ea  [4];
    ops = '{MACL, MAC, MUL, MAC};
    va  = '{8'(10), 8'(10), 8'(2), 8'(-50)};
    vb  = '{8'(10), 8'(10), 8'(2), 8'(4)};
    er  = '{8'(100), 8'h7f, 8'(4), 8'(0)};
    eo  = '{1'b0, 1'b1, 1'b0, 1'b0};
    ea  = '{20'(100), 20'(200), 20'(200), 20'(0)};
    for (int i = 0; i < 4; i++) begin
      issue(va[i], vb[i], ops[i]);
      vectors++;
      if (bus.result !== er[i] || bus.ovf !== eo[i]) begin
        miscompares++;
        $display("FAIL acc_result[%0d] got r=%h o=%b want r=%h o=%b", i, bus.result, bus.ovf, er[i], eo[i]);
      end
      vectors++;
      if (bus.acc !== ea[i]) begin
        miscompares++;
        $display("FAIL acc_value[%0d] got %0d want %0d", i, bus.acc, ea[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    mul_op_t     ops [3];
    logic [7:0]  er  [3];
    logic [19:0] ea  [3];
    ops = '{MACL, MAC, MAC};
    er  = '{8'(9), 8'(18), 8'(27)};
    ea  = '{20'(9), 20'(18), 20'(27)};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        bus.in_valid = 1'b1;
        bus.a        = 8'(3);
        bus.b        = 8'(3);
        bus.op       = ops[i];
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (i >= 1) begin
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.result !== er[i-1] || bus.acc !== ea[i-1]) begin
          miscompares++;
          $display("FAIL b2b[%0d] got v=%b r=%0d acc=%0d want v=1 r=%0d acc=%0d", i-1, bus.out_valid, bus.result, bus.acc, er[i-1], ea[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 8'(1);
    bus.b         = 8'(7);
    bus.op        = MACL;
    step();
    bus.b  = 8'(8);
    bus.op = MAC;
    step();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'(7) || bus.acc !== 20'(7)) begin
      miscompares++;
      $display("FAIL bp_fill got v=%b r=%0d acc=%0d want v=1 r=7 acc=7", bus.out_valid, bus.result, bus.acc);
    end
    bus.out_ready = 1'b0;
    bus.b         = 8'(9);
    bus.op        = MUL;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.result !== 8'(7) || bus.in_ready !== 1'b0 || bus.acc !== 20'(7)) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] got v=%b r=%0d rdy=%b acc=%0d want v=1 r=7 rdy=0 acc=7", k, bus.out_valid, bus.result, bus.in_ready, bus.acc);
      end
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'(15) || bus.acc !== 20'(15)) begin
      miscompares++;
      $display("FAIL bp_release0 got v=%b r=%0d acc=%0d want v=1 r=15 acc=15", bus.out_valid, bus.result, bus.acc);
    end
    step();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'(9) || bus.acc !== 20'(15)) begin
      miscompares++;
      $display("FAIL bp_release1 got v=%b r=%0d acc=%0d want v=1 r=9 acc=15", bus.out_valid, bus.result, bus.acc);
    end
    step();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_midflight();
    issue(8'(5), 8'(11), MACL);
    vectors++; if (bus.acc !== 20'(55)) begin miscompares++; $display("FAIL rst_preload_acc got %0d want 55", bus.acc); end
    bus.in_valid = 1'b1;
    bus.a        = 8'(2);
    bus.b        = 8'(3);
    bus.op       = MUL;
    step();
    bus.a = 8'(4);
    bus.b = 8'(5);
    step();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.acc !== 20'(0) || bus.result !== 8'h00 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_async got v=%b acc=%0d r=%h rdy=%b want v=0 acc=0 r=00 rdy=1", bus.out_valid, bus.acc, bus.result, bus.in_ready);
    end
    #2;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rst_no_stale[%0d] got v=%b rdy=%b want v=0 rdy=1", k, bus.out_valid, bus.in_ready);
      end
    end
    issue(8'(6), 8'(7), MUL);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.result !== 8'(42)) begin
      miscompares++;
      $display("FAIL rst_recover got v=%b r=%0d want v=1 r=42", bus.out_valid, bus.result);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_stream();
    test_saturation();
    test_accumulate();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
